// File: rtl/lag_tracker_pkg.sv
// Shared types, sizing and helpers for the lag tracker.
// Everything is sized from LAG_W and DEPTH_LOG2 so the tracker can be retargeted.
package lag_tracker_pkg;

   localparam int unsigned LAG_W      = 8;
   localparam int unsigned PEAK_W     = 32;
   localparam int unsigned DEPTH_LOG2 = 3;
   localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
   localparam int unsigned LAG_CENTER = 128;
   localparam int          PEAK_MIN   = 4096;
   localparam int unsigned MISS_LIMIT = 4;

   localparam int unsigned SUM_W  = LAG_W + 1 + DEPTH_LOG2;
   localparam int unsigned FILL_W = DEPTH_LOG2 + 1;
   localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);

   typedef enum logic [1:0] {S_WAIT, S_QUAL, S_ACC, S_PUB} state_t;

   typedef logic signed [LAG_W:0]   lag_t;
   typedef logic signed [SUM_W-1:0] sum_t;

   // Map a signed lag onto one of eight bar segments, clamped at both ends.
   function automatic logic [7:0] lag_to_bar(input lag_t lag);
      logic signed [LAG_W+1:0] pos;
      logic signed [LAG_W+1:0] idx;
      pos = (LAG_W+2)'(lag) + $signed((LAG_W+2)'(LAG_CENTER));
      idx = pos >>> (LAG_W - 3);
      if (idx < 0)
         return 8'h01;
      else if (idx > 7)
         return 8'h80;
      else
         return 8'(1) << idx[2:0];
   endfunction

endpackage

// File: rtl/lag_history.sv
// Ring buffer of the most recent accepted lags with a running sum.
// Once full, each push retires the entry at the write pointer (the oldest).
module lag_history
   import lag_tracker_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              clear,
   input  lag_t              lag_s,
   output lag_t              oldest,
   output sum_t              sum,
   output logic [FILL_W-1:0] fill
);

   lag_t                  hist [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr;
   logic                  full;

   assign full   = (fill == FILL_W'(DEPTH));
   assign oldest = hist[wptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         fill <= '0;
         sum  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) hist[i] <= '0;
      end else if (clear) begin
         wptr <= '0;
         fill <= '0;
         sum  <= '0;
      end else if (push) begin
         hist[wptr] <= lag_s;
         wptr       <= wptr + DEPTH_LOG2'(1);
         sum        <= sum + sum_t'(lag_s) - (full ? sum_t'(hist[wptr]) : sum_t'(0));
         fill       <= full ? fill : fill + FILL_W'(1);
      end
   end

endmodule

// File: rtl/lag_tracker.sv
// Qualifies per-frame argmax results, smooths accepted lags and drives a direction bar.
// Published values are registered on the S_ACC -> S_PUB edge so they are visible during S_PUB.
module lag_tracker
   import lag_tracker_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     frame_done,
   input  logic [LAG_W-1:0]         lag_in,
   input  logic signed [PEAK_W-1:0] peak_in,
   output lag_t                     lag_avg,
   output logic                     lag_valid,
   output logic                     lag_update,
   output logic [7:0]               bar_leds,
   output logic [15:0]              frame_count,
   output logic                     overrun
);

   state_t                   state, state_next;
   logic                     fd_prev;
   logic                     edge_c;
   logic [LAG_W-1:0]         lag_q;
   logic signed [PEAK_W-1:0] peak_q;
   lag_t                     lag_s_q;
   logic                     accept_q;
   logic [MISS_W-1:0]        miss_q;

   logic cap, qual, pub, push, drop;

   lag_t              oldest;
   sum_t              sum;
   logic [FILL_W-1:0] fill;
   logic [FILL_W-1:0] fill_after;
   sum_t              sum_after;
   lag_t              avg_acc;

   assign edge_c = frame_done & ~fd_prev;

   lag_history u_hist (
      .clk    (clk),
      .rst    (rst),
      .push   (push),
      .clear  (drop),
      .lag_s  (lag_s_q),
      .oldest (oldest),
      .sum    (sum),
      .fill   (fill)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_WAIT;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      cap        = 1'b0;
      qual       = 1'b0;
      pub        = 1'b0;
      push       = 1'b0;
      drop       = 1'b0;
      case (state)
         S_WAIT: if (edge_c) begin
            state_next = S_QUAL;
            cap        = 1'b1;
         end
         S_QUAL: begin
            state_next = S_ACC;
            qual       = 1'b1;
         end
         S_ACC: begin
            state_next = S_PUB;
            pub        = 1'b1;
            if (accept_q)
               push = 1'b1;
            else if (miss_q >= MISS_W'(MISS_LIMIT - 1))
               drop = 1'b1;
         end
         S_PUB:   state_next = S_WAIT;
         default: state_next = S_WAIT;
      endcase
   end

   // Post-push view of the history, so the average published in S_PUB already includes this frame.
   always_comb begin
      fill_after = (fill == FILL_W'(DEPTH)) ? fill : fill + FILL_W'(1);
      sum_after  = sum + sum_t'(lag_s_q) - ((fill == FILL_W'(DEPTH)) ? sum_t'(oldest) : sum_t'(0));
      avg_acc    = (fill_after < FILL_W'(DEPTH)) ? lag_s_q : lag_t'(sum_after >>> DEPTH_LOG2);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fd_prev     <= 1'b1;
         lag_q       <= '0;
         peak_q      <= '0;
         lag_s_q     <= '0;
         accept_q    <= 1'b0;
         miss_q      <= '0;
         lag_avg     <= '0;
         lag_valid   <= 1'b0;
         lag_update  <= 1'b0;
         bar_leds    <= '0;
         frame_count <= '0;
         overrun     <= 1'b0;
      end else begin
         fd_prev    <= frame_done;
         lag_update <= pub;
         if (edge_c && state != S_WAIT) overrun <= 1'b1;
         if (cap) begin
            lag_q  <= lag_in;
            peak_q <= peak_in;
         end
         if (qual) begin
            lag_s_q     <= lag_t'({1'b0, lag_q}) - lag_t'(LAG_CENTER);
            accept_q    <= (peak_q >= PEAK_MIN);
            frame_count <= frame_count + 16'd1;
         end
         if (pub) begin
            if (accept_q) begin
               miss_q    <= '0;
               lag_avg   <= avg_acc;
               lag_valid <= 1'b1;
               bar_leds  <= lag_to_bar(avg_acc);
            end else begin
               if (miss_q != MISS_W'(MISS_LIMIT)) miss_q <= miss_q + MISS_W'(1);
               if (drop) begin
                  lag_avg   <= '0;
                  lag_valid <= 1'b0;
                  bar_leds  <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lag_tracker.sv
// Scoreboard bench for lag_tracker: a behavioural model queues the expected publication
// for every frame and each lag_update pulse pops and checks one entry.
module tb_lag_tracker;

   logic               clk = 1'b0;
   logic               rst;
   logic               frame_done;
   logic [7:0]         lag_in;
   logic signed [31:0] peak_in;
   logic signed [8:0]  lag_avg;
   logic               lag_valid;
   logic               lag_update;
   logic [7:0]         bar_leds;
   logic [15:0]        frame_count;
   logic               overrun;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      int         avg;
      bit         valid;
      logic [7:0] bar;
      int         fc;
   } exp_t;

   exp_t sb[$];

   int  m_hist[$];
   int  m_miss  = 0;
   int  m_avg   = 0;
   bit  m_valid = 0;
   int  m_fc    = 0;

   lag_tracker dut (
      .clk         (clk),
      .rst         (rst),
      .frame_done  (frame_done),
      .lag_in      (lag_in),
      .peak_in     (peak_in),
      .lag_avg     (lag_avg),
      .lag_valid   (lag_valid),
      .lag_update  (lag_update),
      .bar_leds    (bar_leds),
      .frame_count (frame_count),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   function automatic int floor_div8(input int s);
      if (s >= 0) return s / 8;
      return -((-s + 7) / 8);
   endfunction

   function automatic logic [7:0] model_bar(input int avg, input bit valid);
      int idx;
      if (!valid) return 8'h00;
      idx = (avg + 128) / 32;
      if (idx < 0) idx = 0;
      if (idx > 7) idx = 7;
      return 8'h01 << idx;
   endfunction

   // Advance the model by one processed frame and queue the expected publication.
   task automatic model_frame(input int lag, input int peak);
      exp_t e;
      int   s;
      m_fc++;
      if (peak >= 4096) begin
         m_hist.push_back(lag - 128);
         if (m_hist.size() > 8) void'(m_hist.pop_front());
         m_miss = 0;
         if (m_hist.size() < 8) m_avg = lag - 128;
         else begin
            s = 0;
            foreach (m_hist[i]) s += m_hist[i];
            m_avg = floor_div8(s);
         end
         m_valid = 1;
      end else begin
         if (m_miss < 4) m_miss++;
         if (m_miss == 4) begin
            m_hist.delete();
            m_valid = 0;
         end
      end
      e.avg = m_avg; e.valid = m_valid; e.bar = model_bar(m_avg, m_valid); e.fc = m_fc;
      sb.push_back(e);
   endtask

   task automatic model_reset();
      m_hist.delete();
      m_miss = 0; m_avg = 0; m_valid = 0; m_fc = 0;
      sb.delete();
   endtask

   task automatic check_pub(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         tests++; failed++;
         $display("FAIL %s: lag_update with empty scoreboard", name);
         return;
      end
      e = sb.pop_front();
      tests++;
      if (lag_valid !== e.valid) begin
         failed++; $display("FAIL %s valid: got %0b want %0b", name, lag_valid, e.valid);
      end
      if (e.valid) begin
         tests++;
         if (int'(lag_avg) !== e.avg) begin
            failed++; $display("FAIL %s avg: got %0d want %0d", name, lag_avg, e.avg);
         end
      end
      tests++;
      if (bar_leds !== e.bar) begin
         failed++; $display("FAIL %s bar: got %h want %h", name, bar_leds, e.bar);
      end
      tests++;
      if (int'(frame_count) !== e.fc) begin
         failed++; $display("FAIL %s frame_count: got %0d want %0d", name, frame_count, e.fc);
      end
   endtask

   // One frame: raise frame_done, wait for the publish pulse and check latency, payload and pulse width.
   task automatic send_frame(input int lag, input int peak, input string name);
      int cyc = 0;
      @(posedge clk); #1;
      frame_done = 1'b1; lag_in = 8'(lag); peak_in = 32'(peak);
      model_frame(lag, peak);
      do begin
         @(posedge clk); #1; cyc++;
      end while (!lag_update && cyc < 12);
      tests++;
      if (cyc != 3) begin
         failed++; $display("FAIL %s latency: got %0d want 3", name, cyc);
      end
      if (lag_update) check_pub(name);
      else void'(sb.pop_front());
      frame_done = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (lag_update !== 1'b0) begin
         failed++; $display("FAIL %s pulse width: lag_update still %0b", name, lag_update);
      end
   endtask

   task automatic expect_no_pulse(input int cycles, input string name);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (lag_update) seen++;
      end
      tests++;
      if (seen != 0) begin
         failed++; $display("FAIL %s: %0d lag_update pulses, want 0", name, seen);
      end
   endtask

   task automatic check_all_zero(input string name);
      tests++;
      if ({lag_avg, lag_valid, lag_update, bar_leds, frame_count, overrun} !== '0) begin
         failed++;
         $display("FAIL %s: avg=%0d valid=%0b upd=%0b bar=%h fc=%0d ovr=%0b want all 0",
                  name, lag_avg, lag_valid, lag_update, bar_leds, frame_count, overrun);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; frame_done = 1'b1; lag_in = 8'd0; peak_in = 32'sd0;
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset_held");
      rst = 1'b1;
      expect_no_pulse(6, "reset_release_no_edge");
      check_all_zero("reset_after_release");
      frame_done = 1'b0;
      @(posedge clk);
   endtask

   task automatic test_accept_fill();
      send_frame(138, 10000, "first_frame");
      for (int i = 0; i < 7; i++) send_frame(138, 10000, "fill_repeat");
   endtask

   task automatic test_slide();
      for (int i = 0; i < 8; i++) send_frame(98, 10000, "slide_neg");
   endtask

   task automatic test_rejects();
      for (int i = 0; i < 3; i++) send_frame(200, -5000, "reject_hold");
      send_frame(200, -5000, "reject_drop");
      send_frame(128, 5000, "reacquire");
   endtask

   task automatic test_overrun();
      int n = 0;
      int fc0;
      tests++;
      if (overrun !== 1'b0) begin
         failed++; $display("FAIL overrun_pre: got %0b want 0", overrun);
      end
      fc0 = int'(frame_count);
      @(posedge clk); #1;
      frame_done = 1'b1; lag_in = 8'd140; peak_in = 32'sd9000;
      model_frame(140, 9000);
      @(posedge clk); #1 frame_done = 1'b0;
      @(posedge clk); #1 frame_done = 1'b1; lag_in = 8'd20; peak_in = 32'sd9000;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (lag_update) begin
            n++;
            check_pub("overrun_frame");
         end
      end
      frame_done = 1'b0;
      tests++;
      if (n != 1) begin
         failed++; $display("FAIL overrun_pulses: got %0d want 1", n);
      end
      tests++;
      if (overrun !== 1'b1) begin
         failed++; $display("FAIL overrun_flag: got %0b want 1", overrun);
      end
      tests++;
      if (int'(frame_count) !== fc0 + 1) begin
         failed++; $display("FAIL overrun_count: got %0d want %0d", frame_count, fc0 + 1);
      end
      @(posedge clk);
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      frame_done = 1'b1; lag_in = 8'd150; peak_in = 32'sd9000;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      #1 check_all_zero("reset_mid_acc");
      @(posedge clk); #1 rst = 1'b1;
      expect_no_pulse(6, "reset_mid_release");
      frame_done = 1'b0;
      @(posedge clk);
      send_frame(130, 9000, "after_reset");
   endtask

   initial begin
      test_reset();
      test_accept_fill();
      test_slide();
      test_rejects();
      test_overrun();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
